univ_shreg_n: RTL and testbench

- Parametrised successor to the 4-bit universal shift register: a WIDTH-bit register with hold, shift, load and clear modes.
- Adds rotate, arithmetic shift, cascade serial outputs, and a counted burst-shift engine with a BUSY/DONE handshake.
- Used as a datapath shifter/serialiser in the CPU datapath. Single-step behaviour (START=0) matches the legacy part, generalised to WIDTH bits.

---
 rtl/univ_shreg_n.sv | 162 ++++++++++++++++
 tb/tb_univ_shreg_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shreg_n.sv
// univ_shreg_n -- WIDTH-bit universal shift register with a counted burst engine.
//
// Single-step behaviour (START=0) matches the legacy 4-bit universal shift
// register: every CP edge applies the MODE operation to Q. "Right" means
// toward the higher index, so shift right feeds DSR into Q[0].
//
// MODE encoding:
//   000 hold            001 shift right (DSR->Q[0])
//   010 shift left      011 parallel load (D)
//       (DSL->Q[W-1])
//   100 rotate right    101 rotate left
//   110 arithmetic shift left (toward index 0, MSB retained)
//   111 synchronous clear
//
// Burst engine: in IDLE, START=1 with a shift-class MODE latches MODE and CNT
// without touching Q. The following CNT edges each perform one latched step
// (DSR/DSL still sampled live). DONE pulses for one cycle after the last step;
// CNT=0 produces the DONE pulse right away without entering RUN.
//
// Handshake: BUSY is high exactly while in RUN. DONE is a single-cycle pulse
// in the cycle after a burst ends, never together with BUSY. START is only
// looked at in IDLE, so holding it high in the DONE cycle starts the next
// burst back to back.
//
// Ports:
//   CP        in   clock, rising edge
//   MRN       in   asynchronous active-low master reset
//   MODE      in   [2:0] operation select
//   D         in   [WIDTH-1:0] parallel load data
//   DSR, DSL  in   serial inputs for shift right / shift left
//   START     in   start a counted burst (IDLE only)
//   CNT       in   [CNT_W-1:0] burst step count, sampled with START
//   Q         out  [WIDTH-1:0] register contents
//   SOR       out  cascade out for right shift (Q[WIDTH-1])
//   SOL       out  cascade out for left shift (Q[0])
//   BUSY      out  burst in progress
//   DONE      out  one-cycle burst completion pulse
//   dbg_state out  current FSM state (0 = IDLE, 1 = RUN)
module univ_shreg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             MRN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             DSR,
    input  logic             DSL,
    input  logic             START,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             BUSY,
    output logic             DONE,
    output logic [0:0]       dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASL  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    // One register step for the given operation.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] nxt;
        case (op)
            M_HOLD:  nxt = cur;
            M_SHR:   nxt = {cur[WIDTH-2:0], sr};
            M_SHL:   nxt = {sl, cur[WIDTH-1:1]};
            M_LOAD:  nxt = din;
            M_ROR:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROL:   nxt = {cur[0], cur[WIDTH-1:1]};
            M_ASL:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Only these operations may be repeated by the burst engine; hold, load
    // and clear gain nothing from repetition and execute once instead.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
               (op == M_ROL) || (op == M_ASL);
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                q_d   = step_op(mode_q, q_q, D, DSR, DSL);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (START && is_shift_op(MODE)) begin
                    // Burst setup edge: Q is left untouched.
                    mode_d = MODE;
                    rem_d  = CNT;
                    if (CNT == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    q_d = step_op(MODE, q_q, D, DSR, DSL);
                end
            end
        endcase
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            mode_q  <= M_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign Q         = q_q;
    assign SOR       = q_q[WIDTH-1];
    assign SOL       = q_q[0];
    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_univ_shreg_n.sv
// Testbench for univ_shreg_n (WIDTH=8, CNT_W=4): directed scenarios followed by
// randomized traffic, all checked against a behavioural model that computes
// each step with integer arithmetic.
module tb_univ_shreg_n;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          CP;
    logic          MRN;
    logic [2:0]    MODE;
    logic [W-1:0]  D;
    logic          DSR;
    logic          DSL;
    logic          START;
    logic [CW-1:0] CNT;
    logic [W-1:0]  Q;
    logic          SOR;
    logic          SOL;
    logic          BUSY;
    logic          DONE;
    logic [0:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_q;
    int m_left;
    int m_mode;
    bit m_busy;
    bit m_done;

    univ_shreg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .CP(CP), .MRN(MRN), .MODE(MODE), .D(D), .DSR(DSR), .DSL(DSL),
        .START(START), .CNT(CNT), .Q(Q), .SOR(SOR), .SOL(SOL),
        .BUSY(BUSY), .DONE(DONE), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One step, written as arithmetic on an integer in 0..255.
    function automatic int model_op(input int op, input int v, input int din,
                                    input int sr, input int sl);
        case (op)
            1:       return (v * 2 + sr) % 256;
            2:       return v / 2 + sl * 128;
            3:       return din;
            4:       return (v * 2) % 256 + v / 128;
            5:       return v / 2 + (v % 2) * 128;
            6:       return v / 2 + (v / 128) * 128;
            7:       return 0;
            default: return v;
        endcase
    endfunction

    function automatic bit model_is_shift(input int op);
        return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
    endfunction

    task automatic model_reset();
        m_q    = 0;
        m_left = 0;
        m_mode = 0;
        m_busy = 0;
        m_done = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied for it.
    task automatic model_step();
        bit nd;
        nd = 0;
        if (m_busy) begin
            m_q = model_op(m_mode, m_q, int'(D), int'(DSR), int'(DSL));
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                nd     = 1;
            end
        end else if (START && model_is_shift(int'(MODE))) begin
            m_mode = int'(MODE);
            if (CNT == 0) begin
                nd = 1;
            end else begin
                m_busy = 1;
                m_left = int'(CNT);
            end
        end else begin
            m_q = model_op(int'(MODE), m_q, int'(D), int'(DSR), int'(DSL));
        end
        m_done = nd;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_q"},    32'(Q),    32'(m_q));
        check_eq({tag, "_sor"},  32'(SOR),  32'(m_q / 128));
        check_eq({tag, "_sol"},  32'(SOL),  32'(m_q % 2));
        check_eq({tag, "_busy"}, 32'(BUSY), 32'(m_busy));
        check_eq({tag, "_done"}, 32'(DONE), 32'(m_done));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are already set by the caller; one edge, then sample 1 unit later.
    task automatic do_cycle(input string tag);
        @(posedge CP);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Called 1 unit after an edge: pulse MRN low mid-cycle and check that the
    // reset is visible before any further edge.
    task automatic mid_reset(input string tag);
        MRN = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #2;
        MRN = 1'b1;
    endtask

    task automatic load_val(input logic [W-1:0] v);
        START = 1'b0;
        MODE  = 3'b011;
        D     = v;
        do_cycle("load");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        MRN = 1'b0; MODE = 3'b000; D = '0; DSR = 1'b0; DSL = 1'b0;
        START = 1'b0; CNT = '0;
        model_reset();
        #2;
        compare_all("por");
        #10;
        MRN = 1'b1;

        // 1: asynchronous reset during a burst.
        load_val(8'hFF);
        MODE = 3'b001; START = 1'b1; CNT = 4'd5; DSR = 1'b1;
        do_cycle("t1_start");
        check_eq("t1_busy_before", 32'(BUSY), 32'd1);
        START = 1'b0;
        mid_reset("t1_rst");
        check_eq("t1_rst_q", 32'(Q), 32'h00);
        MODE = 3'b000;
        do_cycle("t1_hold");
        check_eq("t1_hold_q", 32'(Q), 32'h00);

        // 2: load then single shift right.
        load_val(8'hA5);
        check_eq("t2_load_q", 32'(Q), 32'hA5);
        check_eq("t2_sor_pre", 32'(SOR), 32'd1);
        MODE = 3'b001; DSR = 1'b1;
        do_cycle("t2_shr");
        check_eq("t2_shr_q", 32'(Q), 32'h4B);
        check_eq("t2_sor_post", 32'(SOR), 32'd0);

        // 3: rotate-left burst, MODE scribbled during RUN.
        load_val(8'h81);
        MODE = 3'b101; CNT = 4'd3; START = 1'b1;
        do_cycle("t3_start");
        START = 1'b0; MODE = 3'b000;
        do_cycle("t3_s1");
        check_eq("t3_s1_q", 32'(Q), 32'hC0);
        MODE = 3'b011; D = 8'hFF;
        do_cycle("t3_s2");
        check_eq("t3_s2_q", 32'(Q), 32'h60);
        MODE = 3'b111;
        do_cycle("t3_s3");
        check_eq("t3_s3_q", 32'(Q), 32'h30);
        check_eq("t3_done", 32'(DONE), 32'd1);
        MODE = 3'b000;
        do_cycle("t3_after");
        check_eq("t3_done_end", 32'(DONE), 32'd0);

        // 4: arithmetic shift-left burst.
        load_val(8'h90);
        MODE = 3'b110; CNT = 4'd2; START = 1'b1;
        do_cycle("t4_start");
        START = 1'b0; MODE = 3'b000;
        do_cycle("t4_s1");
        check_eq("t4_s1_q", 32'(Q), 32'hC8);
        do_cycle("t4_s2");
        check_eq("t4_s2_q", 32'(Q), 32'hE4);
        check_eq("t4_done", 32'(DONE), 32'd1);
        do_cycle("t4_after");

        // 5: zero-count burst, and START with a non-shift MODE.
        load_val(8'h3C);
        MODE = 3'b001; CNT = 4'd0; START = 1'b1;
        do_cycle("t5_cnt0");
        check_eq("t5_cnt0_q", 32'(Q), 32'h3C);
        check_eq("t5_cnt0_done", 32'(DONE), 32'd1);
        START = 1'b0; MODE = 3'b000;
        do_cycle("t5_idle");
        MODE = 3'b011; D = 8'h11; CNT = 4'd5; START = 1'b1;
        do_cycle("t5_load");
        check_eq("t5_load_q", 32'(Q), 32'h11);
        START = 1'b0; MODE = 3'b000;
        do_cycle("t5_idle2");

        // 6: reset mid-burst, then a full burst and a back-to-back burst.
        load_val(8'h01);
        MODE = 3'b100; CNT = 4'd8; START = 1'b1;
        do_cycle("t6_start");
        START = 1'b0; MODE = 3'b000;
        do_cycle("t6_s1");
        do_cycle("t6_s2");
        check_eq("t6_s2_q", 32'(Q), 32'h04);
        mid_reset("t6_rst");
        do_cycle("t6_released");
        load_val(8'h01);
        MODE = 3'b100; CNT = 4'd8; START = 1'b1;
        do_cycle("t6_restart");
        START = 1'b0;
        for (int i = 0; i < 8; i++) do_cycle("t6_run");
        check_eq("t6_wrap_q", 32'(Q), 32'h01);
        check_eq("t6_wrap_done", 32'(DONE), 32'd1);
        MODE = 3'b100; CNT = 4'd1; START = 1'b1;
        do_cycle("t6_b2b_start");
        check_eq("t6_b2b_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
        do_cycle("t6_b2b_end");
        check_eq("t6_b2b_q", 32'(Q), 32'h02);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            MODE  = 3'($urandom_range(0, 7));
            D     = 8'($urandom_range(0, 255));
            DSR   = 1'($urandom_range(0, 1));
            DSL   = 1'($urandom_range(0, 1));
            START = ($urandom_range(0, 3) == 0);
            CNT   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                do_cycle("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
